// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver-to-host bundle: received byte, strobe, parity flag, busy
interface uart_rx_if;
  logic [7:0] Rx_Data;
  logic       Rx_Valid;
  logic       Parity_Error;
  logic       Rx_Busy;

  modport master (output Rx_Data, output Rx_Valid, output Parity_Error, output Rx_Busy);
  modport slave  (input  Rx_Data, input  Rx_Valid, input  Parity_Error, input  Rx_Busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8E UART receiver: start, 8 data bits LSB first, even parity, no stop bit
module uart_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int HALF_BIT     = 108
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      Rx,
  uart_rx_if.master host
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_PARITY} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_sync1;
  logic            r_rx_s;
  logic            r_rx_prev;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic [7:0]      r_data;
  logic            r_perr;
  logic            r_valid;

  logic            w_fall;
  logic            w_tick;
  logic            w_busy;
  logic            w_load_half;
  logic            w_load_bit;
  logic            w_shift_en;
  logic            w_done;

  assign w_fall = ~r_rx_s & r_rx_prev;
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START:  if (w_tick) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && r_idx == 3'd7) w_next = S_PARITY;
      S_PARITY: if (w_tick) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_load_half = (r_state == S_IDLE) && w_fall;
    w_load_bit  = ((r_state == S_START) && w_tick && !r_rx_s) ||
                  ((r_state == S_DATA) && w_tick);
    w_shift_en  = (r_state == S_DATA) && w_tick;
    w_done      = (r_state == S_PARITY) && w_tick;
  end

  // Synchronisers idle high so a reset never fabricates a falling edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_perr    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_sync1   <= Rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
      r_valid   <= 1'b0;

      if (w_load_half)          r_cnt <= CW'(HALF_BIT - 1);
      else if (w_load_bit)      r_cnt <= CW'(CLKS_PER_BIT - 1);
      else if (w_busy && !w_tick) r_cnt <= r_cnt - 1'b1;

      if (w_load_half || ((r_state == S_START) && w_tick)) r_idx <= 3'd0;
      else if (w_shift_en) begin
        r_shift[r_idx] <= r_rx_s;
        r_idx          <= r_idx + 3'd1;
      end

      if (w_done) begin
        r_data  <= r_shift;
        r_perr  <= (^r_shift) ^ r_rx_s;
        r_valid <= 1'b1;
      end
    end
  end

  assign host.Rx_Data      = r_data;
  assign host.Rx_Valid     = r_valid;
  assign host.Parity_Error = r_perr;
  assign host.Rx_Busy      = w_busy;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed bench for uart_rx at 217 clocks per bit
module tb_uart_rx;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic Rx    = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [7:0] q_data[$];
  logic       q_perr[$];
  int         q_cyc[$];

  uart_rx_if bus();

  uart_rx dut (
    .clock (clock),
    .reset (reset),
    .Rx    (Rx),
    .host  (bus)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.Rx_Valid === 1'b1) begin
      q_data.push_back(bus.Rx_Data);
      q_perr.push_back(bus.Parity_Error);
      q_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    q_data.delete();
    q_perr.delete();
    q_cyc.delete();
  endtask

  task automatic drive_bit(input logic b);
    Rx = b;
    repeat (217) @(negedge clock);
  endtask

  // Strobe is expected at t0 + 2064: 2 synchroniser clocks + 108 + 9*217 + 1.
  task automatic send_frame(input logic [7:0] d, input logic p, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    Rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Rx    = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (bus.Rx_Data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.Rx_Data); end
    total++; if (bus.Rx_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.Rx_Valid); end
    total++; if (bus.Parity_Error !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", bus.Parity_Error); end
    total++; if (bus.Rx_Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.Rx_Busy); end
    reset = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_good_byte();
    int t0;
    clear_log();
    send_frame(8'hA5, 1'b0, t0);
    repeat (30) @(negedge clock);
    total++;
    if (q_data.size() != 1) begin
      bad++; $display("FAIL a5_count got=%0d want=1", q_data.size());
    end else begin
      total++; if (q_data[0] !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", q_data[0]); end
      total++; if (q_perr[0] !== 1'b0) begin bad++; $display("FAIL a5_perr got=%b want=0", q_perr[0]); end
      total++; if (q_cyc[0] != t0 + 2064) begin bad++; $display("FAIL a5_timing got=%0d want=%0d", q_cyc[0] - t0, 2064); end
    end
    total++; if (bus.Rx_Data !== 8'hA5) begin bad++; $display("FAIL a5_hold got=%h want=a5", bus.Rx_Data); end
  endtask

  task automatic test_parity();
    logic [7:0] vd [3] = '{8'h01, 8'h80, 8'h7E};
    logic       vp [3] = '{1'b0, 1'b1, 1'b1};
    logic       ve [3] = '{1'b1, 1'b0, 1'b1};
    int t0;
    for (int k = 0; k < 3; k++) begin
      clear_log();
      send_frame(vd[k], vp[k], t0);
      repeat (30) @(negedge clock);
      total++;
      if (q_data.size() != 1) begin
        bad++; $display("FAIL par%0d_count got=%0d want=1", k, q_data.size());
      end else begin
        total++; if (q_data[0] !== vd[k]) begin bad++; $display("FAIL par%0d_data got=%h want=%h", k, q_data[0], vd[k]); end
        total++; if (q_perr[0] !== ve[k]) begin bad++; $display("FAIL par%0d_perr got=%b want=%b", k, q_perr[0], ve[k]); end
      end
    end
  endtask

  task automatic test_false_start();
    int t0;
    clear_log();
    t0 = cyc;
    Rx = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clock);
      if (k == 50) Rx = 1'b1;
      if (k == 2) begin
        total++; if (bus.Rx_Busy !== 1'b0) begin bad++; $display("FAIL fs_busy_e got=%b want=0", bus.Rx_Busy); end
      end
      if (k == 3) begin
        total++; if (bus.Rx_Busy !== 1'b1) begin bad++; $display("FAIL fs_busy_rise got=%b want=1", bus.Rx_Busy); end
      end
      if (k == 110) begin
        total++; if (bus.Rx_Busy !== 1'b1) begin bad++; $display("FAIL fs_busy_hold got=%b want=1", bus.Rx_Busy); end
      end
      if (k == 111) begin
        total++; if (bus.Rx_Busy !== 1'b0) begin bad++; $display("FAIL fs_busy_fall got=%b want=0", bus.Rx_Busy); end
      end
    end
    total++; if (q_data.size() != 0) begin bad++; $display("FAIL fs_strobe got=%0d want=0", q_data.size()); end
    if (cyc - t0 != 130) $display("note: false-start window drifted");
  endtask

  task automatic test_back_to_back();
    int t0;
    int t1;
    clear_log();
    send_frame(8'h00, 1'b0, t0);
    @(negedge clock);
    send_frame(8'hFF, 1'b0, t1);
    repeat (30) @(negedge clock);
    total++;
    if (q_data.size() != 2) begin
      bad++; $display("FAIL b2b_count got=%0d want=2", q_data.size());
    end else begin
      total++; if (q_data[0] !== 8'h00) begin bad++; $display("FAIL b2b_data0 got=%h want=00", q_data[0]); end
      total++; if (q_perr[0] !== 1'b0) begin bad++; $display("FAIL b2b_perr0 got=%b want=0", q_perr[0]); end
      total++; if (q_data[1] !== 8'hFF) begin bad++; $display("FAIL b2b_data1 got=%h want=ff", q_data[1]); end
      total++; if (q_perr[1] !== 1'b0) begin bad++; $display("FAIL b2b_perr1 got=%b want=0", q_perr[1]); end
      total++; if (q_cyc[1] != t1 + 2064) begin bad++; $display("FAIL b2b_timing got=%0d want=%0d", q_cyc[1] - t1, 2064); end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d = 8'h3C;
    int t0;
    clear_log();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    Rx = d[4];
    repeat (100) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total++; if (bus.Rx_Busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.Rx_Busy); end
    total++; if (bus.Rx_Data !== 8'h00) begin bad++; $display("FAIL abort_data got=%h want=00", bus.Rx_Data); end
    total++; if (bus.Parity_Error !== 1'b0) begin bad++; $display("FAIL abort_perr got=%b want=0", bus.Parity_Error); end
    repeat (114) @(negedge clock);
    Rx    = 1'b1;
    reset = 1'b0;
    repeat (300) @(negedge clock);
    total++; if (q_data.size() != 0) begin bad++; $display("FAIL abort_partial got=%0d want=0", q_data.size()); end
    send_frame(8'hC3, 1'b0, t0);
    repeat (30) @(negedge clock);
    total++;
    if (q_data.size() != 1) begin
      bad++; $display("FAIL c3_count got=%0d want=1", q_data.size());
    end else begin
      total++; if (q_data[0] !== 8'hC3) begin bad++; $display("FAIL c3_data got=%h want=c3", q_data[0]); end
      total++; if (q_perr[0] !== 1'b0) begin bad++; $display("FAIL c3_perr got=%b want=0", q_perr[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_parity();
    test_false_start();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
